clock_activity_monitor: RTL

- Decides whether a monitored clock is running by counting its edges over fixed windows of a reference clock, with hysteresis.
- Sits directly upstream of the priority clock selector: its clock_running output, inverted, drives the mux select.
- Runs entirely in the reference (always-on, fallback) clock domain.
- The only cross-domain input is a toggle signal produced by a single toggle flop in the monitored domain.

---
 rtl/clock_monitor_pkg.sv | 26 ++
 rtl/clock_activity_monitor_window.sv | 72 +++++++
 rtl/clock_activity_monitor.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/clock_monitor_pkg.sv
// Shared definitions for the clock activity monitor: FSM state encodings
// and a constant-evaluable ceiling log2 used to size counters.
package clock_monitor_pkg;

  // Bit 1 of the encoding is the clock_running indication.
  typedef enum logic [1:0] {
    STOPPED  = 2'b00,
    STARTING = 2'b01,
    RUNNING  = 2'b11,
    STOPPING = 2'b10
  } monitor_state_t;

  // Ceiling log2; returns the number of bits needed to index 'value' items.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/clock_activity_monitor_window.sv
// Window edge counter: synchronizes the monitored toggle into the reference
// domain, turns each toggle transition into one edge, and counts edges over
// fixed windows of reference cycles.
module window_edge_counter
  import clock_monitor_pkg::*;
#(
  parameter int STAGES        = 2,
  parameter int WINDOW_CYCLES = 64,
  parameter int MIN_EDGES     = 4,
  parameter int COUNT_WIDTH   = clog2(WINDOW_CYCLES + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   monitored_toggle,
  output logic                   window_end,
  output logic                   pass,
  output logic [COUNT_WIDTH-1:0] total
);

  localparam logic [COUNT_WIDTH-1:0] LAST_CYCLE = COUNT_WIDTH'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] MIN_COUNT  = COUNT_WIDTH'(MIN_EDGES);

  logic [STAGES-1:0]      sync_q;
  logic [STAGES-1:0]      sync_d;
  logic                   edge_prev_q;
  logic                   edge_prev_d;
  logic [COUNT_WIDTH-1:0] window_count_q;
  logic [COUNT_WIDTH-1:0] window_count_d;
  logic [COUNT_WIDTH-1:0] edge_count_q;
  logic [COUNT_WIDTH-1:0] edge_count_d;
  logic                   sync_out;
  logic                   edge_pulse;
  logic                   last_cycle;

  // Edge extraction and window bookkeeping; the synchronizer and edge-detect
  // flop always track so that re-enabling never produces a spurious edge.
  always_comb begin
    sync_d      = {sync_q[STAGES-2:0], monitored_toggle};
    sync_out    = sync_q[STAGES-1];
    edge_prev_d = sync_out;
    edge_pulse  = sync_out ^ edge_prev_q;

    last_cycle  = (window_count_q == LAST_CYCLE);
    window_end  = enable & last_cycle;
    total       = edge_count_q + {{(COUNT_WIDTH-1){1'b0}}, edge_pulse};
    pass        = (total >= MIN_COUNT);

    window_count_d = '0;
    edge_count_d   = '0;
    if (enable && !last_cycle) begin
      window_count_d = window_count_q + COUNT_WIDTH'(1);
      edge_count_d   = total;
    end
  end

  // Register the synchronizer chain, edge-detect history and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q         <= '0;
      edge_prev_q    <= 1'b0;
      window_count_q <= '0;
      edge_count_q   <= '0;
    end else begin
      sync_q         <= sync_d;
      edge_prev_q    <= edge_prev_d;
      window_count_q <= window_count_d;
      edge_count_q   <= edge_count_d;
    end
  end

endmodule

// File: rtl/clock_activity_monitor.sv
// Clock activity monitor: declares the monitored clock running or stopped
// from per-window edge counts, with hysteresis in both directions.
module clock_activity_monitor
  import clock_monitor_pkg::*;
#(
  parameter int  STAGES           = 2,
  parameter int  WINDOW_CYCLES    = 64,
  parameter int  MIN_EDGES        = 4,
  parameter int  ASSERT_WINDOWS   = 2,
  parameter int  DEASSERT_WINDOWS = 2,
  localparam int COUNT_WIDTH      = clog2(WINDOW_CYCLES + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   monitored_toggle,
  output logic                   clock_running,
  output logic                   clock_started,
  output logic                   clock_lost,
  output logic                   window_done,
  output logic [COUNT_WIDTH-1:0] last_edge_count
);

  localparam int STREAK_MAX   = (ASSERT_WINDOWS > DEASSERT_WINDOWS) ? ASSERT_WINDOWS
                                                                    : DEASSERT_WINDOWS;
  localparam int STREAK_WIDTH = clog2(STREAK_MAX + 1);
  localparam logic [STREAK_WIDTH-1:0] ASSERT_TARGET   = STREAK_WIDTH'(ASSERT_WINDOWS);
  localparam logic [STREAK_WIDTH-1:0] DEASSERT_TARGET = STREAK_WIDTH'(DEASSERT_WINDOWS);
  localparam logic [STREAK_WIDTH-1:0] STREAK_ONE      = STREAK_WIDTH'(1);

  if (STAGES < 2) begin : g_bad_stages
    $error("clock_activity_monitor: STAGES must be >= 2");
  end
  if (WINDOW_CYCLES < 2) begin : g_bad_window
    $error("clock_activity_monitor: WINDOW_CYCLES must be >= 2");
  end
  if (MIN_EDGES < 1 || MIN_EDGES > WINDOW_CYCLES) begin : g_bad_min_edges
    $error("clock_activity_monitor: MIN_EDGES must be in 1..WINDOW_CYCLES");
  end
  if (ASSERT_WINDOWS < 1) begin : g_bad_assert
    $error("clock_activity_monitor: ASSERT_WINDOWS must be >= 1");
  end
  if (DEASSERT_WINDOWS < 1) begin : g_bad_deassert
    $error("clock_activity_monitor: DEASSERT_WINDOWS must be >= 1");
  end

  logic                    window_end;
  logic                    pass;
  logic [COUNT_WIDTH-1:0]  total;

  monitor_state_t          state_q;
  monitor_state_t          state_d;
  logic [STREAK_WIDTH-1:0] streak_q;
  logic [STREAK_WIDTH-1:0] streak_d;
  logic [STREAK_WIDTH-1:0] streak_inc;
  logic [COUNT_WIDTH-1:0]  last_edge_count_q;
  logic [COUNT_WIDTH-1:0]  last_edge_count_d;
  logic                    clock_running_q;
  logic                    clock_running_d;
  logic                    clock_started_q;
  logic                    clock_started_d;
  logic                    clock_lost_q;
  logic                    clock_lost_d;
  logic                    window_done_q;
  logic                    window_done_d;

  window_edge_counter #(
    .STAGES        (STAGES),
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .MIN_EDGES     (MIN_EDGES),
    .COUNT_WIDTH   (COUNT_WIDTH)
  ) u_window (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .monitored_toggle (monitored_toggle),
    .window_end       (window_end),
    .pass             (pass),
    .total            (total)
  );

  // Hysteresis FSM: only a completed window can move the state, and the
  // streak counts consecutive windows that argue for the opposite state.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    streak_inc = streak_q + STREAK_ONE;
    if (window_end) begin
      case (state_q)
        STOPPED: begin
          if (pass) begin
            if (ASSERT_WINDOWS == 1) begin
              state_d = RUNNING;
            end else begin
              state_d  = STARTING;
              streak_d = STREAK_ONE;
            end
          end
        end
        STARTING: begin
          if (!pass) begin
            state_d  = STOPPED;
            streak_d = '0;
          end else if (streak_inc == ASSERT_TARGET) begin
            state_d  = RUNNING;
            streak_d = '0;
          end else begin
            streak_d = streak_inc;
          end
        end
        RUNNING: begin
          if (!pass) begin
            if (DEASSERT_WINDOWS == 1) begin
              state_d = STOPPED;
            end else begin
              state_d  = STOPPING;
              streak_d = STREAK_ONE;
            end
          end
        end
        STOPPING: begin
          if (pass) begin
            state_d  = RUNNING;
            streak_d = '0;
          end else if (streak_inc == DEASSERT_TARGET) begin
            state_d  = STOPPED;
            streak_d = '0;
          end else begin
            streak_d = streak_inc;
          end
        end
        default: begin
          state_d  = STOPPED;
          streak_d = '0;
        end
      endcase
    end

    last_edge_count_d = window_end ? total : last_edge_count_q;
    window_done_d     = window_end;
    clock_running_d   = state_d[1];
    clock_started_d   = window_end & ~state_q[1] &  state_d[1];
    clock_lost_d      = window_end &  state_q[1] & ~state_d[1];
  end

  // Register FSM state, streak and every output so they change together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= STOPPED;
      streak_q          <= '0;
      last_edge_count_q <= '0;
      clock_running_q   <= 1'b0;
      clock_started_q   <= 1'b0;
      clock_lost_q      <= 1'b0;
      window_done_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      streak_q          <= streak_d;
      last_edge_count_q <= last_edge_count_d;
      clock_running_q   <= clock_running_d;
      clock_started_q   <= clock_started_d;
      clock_lost_q      <= clock_lost_d;
      window_done_q     <= window_done_d;
    end
  end

  assign clock_running   = clock_running_q;
  assign clock_started   = clock_started_q;
  assign clock_lost      = clock_lost_q;
  assign window_done     = window_done_q;
  assign last_edge_count = last_edge_count_q;

endmodule
